// File: rtl/cpu_pkg.sv
// Shared CPU defaults and register-index type for the integer register file.
package cpu_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned REG_AW    = $clog2(NREGS_DEF);

    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wr_select.sv
// Finds the highest-priority effective write port targeting a given register.
module regfile_wr_select #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NWR     = 2,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic [AW-1:0]       addr,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                hit_c,
    output logic [XLEN-1:0]     data_c
);

    // Ascending scan so the highest-index matching port is the one left standing.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && !(R0_ZERO && wr_addr[j*AW +: AW] == '0) &&
                wr_addr[j*AW +: AW] == addr) begin
                hit_c  = 1'b1;
                data_c = wr_data[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass and a write-pending scoreboard.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 2,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]         wr_data,
    input  logic                        alloc_en,
    input  logic [$clog2(NREGS)-1:0]    alloc_addr,
    input  logic                        flush,
    output logic [$clog2(NREGS):0]      busy_count
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs    [NREGS];
    logic [XLEN-1:0]  cm_data [NREGS];
    logic [NREGS-1:0] cm_hit;
    logic [NREGS-1:0] valid;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++) begin
            n = n + (AW+1)'(v[i]);
        end
        return n;
    endfunction

    // Per-register write resolution shared by data commit and busy clear.
    for (genvar i = 0; i < NREGS; i++) begin : g_commit
        regfile_wr_select #(
            .XLEN(XLEN), .AW(AW), .NWR(NWR), .R0_ZERO(R0_ZERO)
        ) u_sel (
            .addr   (AW'(i)),
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .hit_c  (cm_hit[i]),
            .data_c (cm_data[i])
        );
    end

    // Data storage is not reset; valid bits hide stale contents instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!reset && cm_hit[i]) begin
                regs[i] <= cm_data[i];
            end
        end
    end

    // Busy next state: write clear, then flush, then new allocation.
    always_comb begin
        busy_nxt = busy & ~cm_hit;
        if (flush) begin
            busy_nxt = '0;
        end
        if (alloc_en && !(R0_ZERO && alloc_addr == '0)) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
    end

    // Scoreboard and valid state with immediate asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            valid      <= valid | cm_hit;
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

    // Read ports with same-cycle write bypass.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] byp;
        logic [XLEN-1:0] dat;
        logic            bsy;

        assign ra = rd_addr[k*AW +: AW];

        regfile_wr_select #(
            .XLEN(XLEN), .AW(AW), .NWR(NWR), .R0_ZERO(R0_ZERO)
        ) u_sel (
            .addr   (ra),
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .hit_c  (hit),
            .data_c (byp)
        );

        // Priority: hardwired zero, bypass, never-written, storage.
        always_comb begin
            dat = '0;
            bsy = 1'b0;
            if (R0_ZERO && ra == '0) begin
                dat = '0;
            end else if (hit) begin
                dat = byp;
            end else if (valid[ra]) begin
                dat = regs[ra];
            end
            if (!(R0_ZERO && ra == '0)) begin
                bsy = busy[ra] && !hit;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = dat;
        assign rd_busy[k]              = bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
    import cpu_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic                 flush;
    logic [AW:0]          busy_count;

    // reference model state
    logic [XLEN-1:0] m_regs  [NREGS];
    bit              m_valid [NREGS];
    bit              m_busy  [NREGS];
    int              m_count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .R0_ZERO(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .flush     (flush),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit eff_wr(input int j);
        return wr_en[j] && (wr_addr[j*AW +: AW] != '0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_valid[i] = 1'b0;
            m_busy[i]  = 1'b0;
        end
        m_count = 0;
    endtask

    // Expected read result from the architectural rules.
    task automatic model_read(input reg_idx_t a, output logic [XLEN-1:0] d, output bit b);
        bit hit;
        hit = 1'b0;
        d   = '0;
        b   = 1'b0;
        if (a != 0) begin
            for (int j = NWR - 1; j >= 0; j--) begin
                if (!hit && eff_wr(j) && wr_addr[j*AW +: AW] == a) begin
                    hit = 1'b1;
                    d   = wr_data[j*XLEN +: XLEN];
                end
            end
            if (!hit) d = m_valid[a] ? m_regs[a] : '0;
            b = m_busy[a] && !hit;
        end
    endtask

    task automatic model_clock();
        int c;
        for (int j = 0; j < NWR; j++) begin
            if (eff_wr(j)) begin
                m_regs[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
                m_valid[wr_addr[j*AW +: AW]] = 1'b1;
                m_busy[wr_addr[j*AW +: AW]]  = 1'b0;
            end
        end
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        m_count = c;
    endtask

    task automatic compare_all();
        logic [XLEN-1:0] ed;
        bit              eb;
        reg_idx_t        a;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            model_read(a, ed, eb);
            chk($sformatf("rd_data%0d_x%0d", k, a), 64'(rd_data[k*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("rd_busy%0d_x%0d", k, a), 64'(rd_busy[k]), 64'(eb));
        end
        chk("busy_count", 64'(busy_count), 64'(m_count));
    endtask

    // Compare mid-cycle, then advance the model with the DUT at the edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (!reset) model_clock();
        #1;
    endtask

    task automatic clr();
        wr_en    = '0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input int k, input reg_idx_t a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input reg_idx_t a, input logic [XLEN-1:0] d);
        wr_en[j]                = 1'b1;
        wr_addr[j*AW +: AW]     = a;
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input reg_idx_t a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    initial begin
        reset      = 1'b1;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        set_rd(0, 5); set_rd(1, 5);
        #1;
        chk("reset_busy_count", 64'(busy_count), 64'd0);
        chk("reset_rd_data_x5", 64'(rd_data[31:0]), 64'd0);
        chk("reset_rd_busy", 64'(rd_busy), 64'd0);
        reset = 1'b0;
        step();

        // write bypass then storage
        set_wr(0, 5, 32'hDEADBEEF);
        #2 chk("bypass_x5", 64'(rd_data[63:32]), 64'hDEADBEEF);
        step(); clr();
        #2 chk("stored_x5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        step();

        // same-address write on both ports: port 1 wins
        set_rd(0, 7); set_rd(1, 7);
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
        #2 chk("bypass_x7_prio", 64'(rd_data[31:0]), 64'h22);
        step(); clr();
        #2 chk("stored_x7_prio", 64'(rd_data[63:32]), 64'h22);
        step();

        // x0 is hardwired
        set_rd(0, 0); set_rd(1, 0);
        set_wr(0, 0, 32'hFFFFFFFF); set_alloc(0);
        #2 chk("x0_bypass", 64'(rd_data[31:0]), 64'd0);
        step(); clr();
        #2 chk("x0_busy", 64'(rd_busy), 64'd0);
        chk("x0_count", 64'(busy_count), 64'd0);
        step();

        // alloc then write-clear, then alloc+write same cycle
        set_rd(0, 3); set_rd(1, 3);
        set_alloc(3);
        #2 chk("alloc_not_bypassed", 64'(rd_busy[0]), 64'd0);
        step(); clr();
        #2 chk("alloc_x3_busy", 64'(rd_busy[0]), 64'd1);
        chk("alloc_x3_count", 64'(busy_count), 64'd1);
        step();
        set_wr(1, 3, 32'h33);
        #2 chk("wr_clear_bypass", 64'(rd_busy[1]), 64'd0);
        step(); clr();
        set_wr(0, 3, 32'h34); set_alloc(3);
        step(); clr();
        #2 chk("alloc_wr_same_busy", 64'(rd_busy[0]), 64'd1);
        step();
        set_wr(0, 3, 32'h35);
        step(); clr();

        // flush with simultaneous alloc
        set_alloc(1); step();
        set_alloc(2); step();
        set_alloc(4); step(); clr();
        #2 chk("count_three", 64'(busy_count), 64'd3);
        flush = 1'b1; set_alloc(9);
        step(); clr();
        set_rd(0, 9); set_rd(1, 1);
        #2 chk("flush_count", 64'(busy_count), 64'd1);
        chk("flush_x9_busy", 64'(rd_busy[0]), 64'd1);
        chk("flush_x1_idle", 64'(rd_busy[1]), 64'd0);
        step();

        // asynchronous reset mid-cycle
        set_wr(0, 6, 32'h5A); set_alloc(8);
        step(); clr();
        set_rd(0, 6); set_rd(1, 8);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_x6", 64'(rd_data[31:0]), 64'd0);
        chk("async_rst_x8", 64'(rd_busy[1]), 64'd0);
        chk("async_rst_count", 64'(busy_count), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        set_wr(1, 6, 32'hA5);
        step(); clr();
        #2 chk("post_rst_x6", 64'(rd_data[31:0]), 64'hA5);
        step();

        // randomized traffic biased toward a few registers for collisions
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NRD; k++)
                set_rd(k, reg_idx_t'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31)));
            for (int j = 0; j < NWR; j++) begin
                wr_en[j]                = ($urandom_range(0, 1) != 0);
                wr_addr[j*AW +: AW]     = reg_idx_t'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            alloc_en   = ($urandom_range(0, 1) != 0);
            alloc_addr = reg_idx_t'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
            flush      = ($urandom_range(0, 15) == 0);
            step();
        end
        clr();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
